// File: rtl/smem_req_queue.sv
// rtl/smem_req_queue.sv - SMEM request queue: pairs parked pipeline entries with DRAM responses
//
// Purpose: pipeline entries go through a QUERY_LAT-stage delay line and are joined with the
//   query nucleobase. Valid entries are then parked in an entry ring. The output stage pairs
//   the ring head with the oldest DRAM response, retires F_break heads without a response,
//   or injects a new read when the response FIFO is empty.
// Ports: Clk_32UI/reset_n (async, active low); stall freezes the output stage only;
//   in_status/in_payload   pipeline entry, query_pos_2RAM = forward_i field of in_payload;
//   query_data             nucleobase, QUERY_LAT cycles after its entry;
//   mem_valid/mem_data     DRAM response into the response FIFO;
//   load_done/new_read_valid/new_read_payload/new_read   new-read injection handshake;
//   out_status/out_payload/out_query/out_mem              registered output stage;
//   ent_count/mem_count/ent_full/mem_full/ovf_err         occupancy and overflow flags.
// Payload layout (LSB up): min_intv [6:0], forward_i [13:7], then ik_*, read_num, ptr_curr.
// Optional: define SMEM_QUEUE_STATS_EN to add stat_pair/stat_break/stat_inject/stat_bubble.

module smem_req_queue #(
    parameter int PAYLOAD_W = 294,
    parameter int MEM_W     = 768,
    parameter int DEPTH     = 256,
    parameter int MEM_DEPTH = 32,
    parameter int QUERY_LAT = 3
) (
    input  logic                           Clk_32UI,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic [5:0]                     in_status,
    input  logic [PAYLOAD_W-1:0]           in_payload,
    output logic [6:0]                     query_pos_2RAM,
    input  logic [7:0]                     query_data,
    input  logic                           mem_valid,
    input  logic [MEM_W-1:0]               mem_data,
    input  logic                           load_done,
    input  logic                           new_read_valid,
    input  logic [PAYLOAD_W-1:0]           new_read_payload,
    output logic                           new_read,
    output logic [5:0]                     out_status,
    output logic [PAYLOAD_W-1:0]           out_payload,
    output logic [7:0]                     out_query,
    output logic [MEM_W-1:0]               out_mem,
    output logic [$clog2(DEPTH):0]         ent_count,
    output logic [$clog2(MEM_DEPTH):0]     mem_count,
    output logic                           ent_full,
    output logic                           mem_full,
    output logic                           ovf_err
`ifdef SMEM_QUEUE_STATS_EN
    ,
    output logic [31:0]                    stat_pair,
    output logic [31:0]                    stat_break,
    output logic [31:0]                    stat_inject,
    output logic [31:0]                    stat_bubble
`endif
);

    localparam int EA      = $clog2(DEPTH);
    localparam int MA      = $clog2(MEM_DEPTH);
    localparam int ENT_W   = 6 + PAYLOAD_W + 8;
    localparam int FWD_LSB = 7;

    localparam logic [5:0] ST_INIT   = 6'd0;
    localparam logic [5:0] ST_RUN    = 6'd1;
    localparam logic [5:0] ST_BREAK  = 6'd2;
    localparam logic [5:0] ST_BUBBLE = 6'b110000;

    assign query_pos_2RAM = in_payload[FWD_LSB +: 7];

    // Delay line: aligns each entry with its query RAM read data.
    logic [5:0]           r_dl_status  [QUERY_LAT];
    logic [PAYLOAD_W-1:0] r_dl_payload [QUERY_LAT];

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUERY_LAT; i++) begin
                r_dl_status[i]  <= ST_BUBBLE;
                r_dl_payload[i] <= '0;
            end
        end else begin
            r_dl_status[0]  <= in_status;
            r_dl_payload[0] <= in_payload;
            for (int i = 1; i < QUERY_LAT; i++) begin
                r_dl_status[i]  <= r_dl_status[i-1];
                r_dl_payload[i] <= r_dl_payload[i-1];
            end
        end
    end

    logic [5:0] w_dl_status;
    logic       w_ent_push;
    assign w_dl_status = r_dl_status[QUERY_LAT-1];
    assign w_ent_push  = (w_dl_status == ST_INIT) || (w_dl_status == ST_RUN) ||
                         (w_dl_status == ST_BREAK);

    // Entry ring
    logic [ENT_W-1:0] r_ent_mem [DEPTH];
    logic [EA:0]      r_ent_wr;
    logic [EA:0]      r_ent_rd;
    logic             w_ent_empty;
    logic             w_ent_full;
    logic             w_ent_pop;
    logic [ENT_W-1:0] w_head;
    logic [5:0]       w_head_status;
    logic             w_head_break;

    assign w_ent_empty   = (r_ent_wr == r_ent_rd);
    assign w_ent_full    = (r_ent_wr[EA] != r_ent_rd[EA]) &&
                           (r_ent_wr[EA-1:0] == r_ent_rd[EA-1:0]);
    assign w_head        = r_ent_mem[r_ent_rd[EA-1:0]];
    assign w_head_status = w_head[ENT_W-1 -: 6];
    assign w_head_break  = !w_ent_empty && (w_head_status == ST_BREAK);

    always_ff @(posedge Clk_32UI) begin
        if (w_ent_push && !w_ent_full)
            r_ent_mem[r_ent_wr[EA-1:0]] <= {w_dl_status, r_dl_payload[QUERY_LAT-1], query_data};
    end

    // Response FIFO
    logic [MEM_W-1:0] r_mem_buf [MEM_DEPTH];
    logic [MA:0]      r_mem_wr;
    logic [MA:0]      r_mem_rd;
    logic             w_mem_empty;
    logic             w_mem_full;
    logic             w_mem_pop;

    assign w_mem_empty = (r_mem_wr == r_mem_rd);
    assign w_mem_full  = (r_mem_wr[MA] != r_mem_rd[MA]) &&
                         (r_mem_wr[MA-1:0] == r_mem_rd[MA-1:0]);

    always_ff @(posedge Clk_32UI) begin
        if (mem_valid && !w_mem_full)
            r_mem_buf[r_mem_wr[MA-1:0]] <= mem_data;
    end

    // Output-stage selection; all selects stay low while stalled.
    logic w_sel_break;
    logic w_sel_pair;
    logic w_sel_inject;
    logic w_sel_bubble;

    always_comb begin
        w_sel_break  = 1'b0;
        w_sel_pair   = 1'b0;
        w_sel_inject = 1'b0;
        w_sel_bubble = 1'b0;
        if (!stall) begin
            if (w_head_break)
                w_sel_break = 1'b1;
            else if (!w_ent_empty && !w_mem_empty)
                w_sel_pair = 1'b1;
            else if (w_mem_empty && load_done && new_read_valid)
                w_sel_inject = 1'b1;
            else
                w_sel_bubble = 1'b1;
        end
    end

    assign new_read  = w_sel_inject;
    assign w_ent_pop = w_sel_break || w_sel_pair;
    assign w_mem_pop = w_sel_pair;

    // Pointers and sticky overflow. A write while full is dropped even if a pop
    // happens in the same cycle.
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            r_ent_wr <= '0;
            r_ent_rd <= '0;
            r_mem_wr <= '0;
            r_mem_rd <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (w_ent_push && !w_ent_full) r_ent_wr <= r_ent_wr + 1'b1;
            if (w_ent_pop)                 r_ent_rd <= r_ent_rd + 1'b1;
            if (mem_valid && !w_mem_full)  r_mem_wr <= r_mem_wr + 1'b1;
            if (w_mem_pop)                 r_mem_rd <= r_mem_rd + 1'b1;
            if ((w_ent_push && w_ent_full) || (mem_valid && w_mem_full))
                ovf_err <= 1'b1;
        end
    end

    assign ent_count = r_ent_wr - r_ent_rd;
    assign mem_count = r_mem_wr - r_mem_rd;
    assign ent_full  = w_ent_full;
    assign mem_full  = w_mem_full;

    // Registered output stage; holds while stalled.
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            out_status  <= ST_BUBBLE;
            out_payload <= '0;
            out_query   <= '0;
            out_mem     <= '0;
        end else if (w_sel_break) begin
            out_status  <= w_head_status;
            out_payload <= w_head[8 +: PAYLOAD_W];
            out_query   <= w_head[7:0];
            out_mem     <= '0;
        end else if (w_sel_pair) begin
            out_status  <= w_head_status;
            out_payload <= w_head[8 +: PAYLOAD_W];
            out_query   <= w_head[7:0];
            out_mem     <= r_mem_buf[r_mem_rd[MA-1:0]];
        end else if (w_sel_inject) begin
            out_status  <= ST_INIT;
            out_payload <= new_read_payload;
            out_query   <= '0;
            out_mem     <= '0;
        end else if (w_sel_bubble) begin
            out_status  <= ST_BUBBLE;
            out_payload <= '1;
            out_query   <= '1;
            out_mem     <= '1;
        end
    end

`ifdef SMEM_QUEUE_STATS_EN
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            stat_pair   <= '0;
            stat_break  <= '0;
            stat_inject <= '0;
            stat_bubble <= '0;
        end else begin
            if (w_sel_pair   && stat_pair   != '1) stat_pair   <= stat_pair   + 32'd1;
            if (w_sel_break  && stat_break  != '1) stat_break  <= stat_break  + 32'd1;
            if (w_sel_inject && stat_inject != '1) stat_inject <= stat_inject + 32'd1;
            if (w_sel_bubble && stat_bubble != '1) stat_bubble <= stat_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_smem_req_queue.sv
// tb/tb_smem_req_queue.sv - directed self-checking bench for smem_req_queue

module tb_smem_req_queue;

    localparam int PW  = 294;
    localparam int MW  = 768;
    localparam int DEP = 16;
    localparam int MD  = 4;
    localparam int QL  = 3;
    localparam int EA  = $clog2(DEP);
    localparam int MA  = $clog2(MD);
    localparam logic [5:0] BUB = 6'b110000;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           stall = 1'b0;
    logic [5:0]     in_status = BUB;
    logic [PW-1:0]  in_payload = '0;
    logic [6:0]     query_pos_2RAM;
    logic [7:0]     query_data = '0;
    logic           mem_valid = 1'b0;
    logic [MW-1:0]  mem_data = '0;
    logic           load_done = 1'b0;
    logic           new_read_valid = 1'b0;
    logic [PW-1:0]  new_read_payload = '0;
    logic           new_read;
    logic [5:0]     out_status;
    logic [PW-1:0]  out_payload;
    logic [7:0]     out_query;
    logic [MW-1:0]  out_mem;
    logic [EA:0]    ent_count;
    logic [MA:0]    mem_count;
    logic           ent_full;
    logic           mem_full;
    logic           ovf_err;

    int total = 0;
    int bad   = 0;

    smem_req_queue #(
        .PAYLOAD_W(PW), .MEM_W(MW), .DEPTH(DEP), .MEM_DEPTH(MD), .QUERY_LAT(QL)
    ) dut (
        .Clk_32UI(clk), .reset_n(reset_n), .stall(stall),
        .in_status(in_status), .in_payload(in_payload),
        .query_pos_2RAM(query_pos_2RAM), .query_data(query_data),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .load_done(load_done), .new_read_valid(new_read_valid),
        .new_read_payload(new_read_payload), .new_read(new_read),
        .out_status(out_status), .out_payload(out_payload),
        .out_query(out_query), .out_mem(out_mem),
        .ent_count(ent_count), .mem_count(mem_count),
        .ent_full(ent_full), .mem_full(mem_full), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mk(input int n);
        logic [PW-1:0] p;
        p = '0;
        p[31:0] = n;
        p[PW-1 -: 32] = ~n;
        return p;
    endfunction

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [PW-1:0] pa, pb, pn;
    logic [MW-1:0] ma, mb, mc;
    logic [PW-1:0] ones_p;
    logic [MW-1:0] ones_m;

    initial begin
        ones_p = '1;
        ones_m = '1;
        ma = {24{32'hA5A50001}};
        mb = {24{32'hA5A50002}};
        mc = {24{32'hA5A50003}};

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_status",  1024'(out_status), 1024'(BUB));
        chk("rst_payload", 1024'(out_payload), 1024'(0));
        chk("rst_mem",     1024'(out_mem), 1024'(0));
        chk("rst_entcnt",  1024'(ent_count), 1024'(0));
        chk("rst_memcnt",  1024'(mem_count), 1024'(0));
        chk("rst_ovf",     1024'(ovf_err), 1024'(0));
        tick();
        reset_n = 1'b1;

        // Idle: bubbles, all-ones fields
        tick(); tick(); tick();
        chk("idle_status",  1024'(out_status), 1024'(BUB));
        chk("idle_payload", 1024'(out_payload), 1024'(ones_p));
        chk("idle_mem",     1024'(out_mem), 1024'(ones_m));
        chk("idle_newread", 1024'(new_read), 1024'(0));
        chk("idle_entcnt",  1024'(ent_count), 1024'(0));

        // query_pos_2RAM is the forward_i field (bits 13:7)
        in_payload = '0;
        in_payload[13:7] = 7'h55;
        #1;
        chk("qpos", 1024'(query_pos_2RAM), 1024'(7'h55));
        in_payload = '0;

        // New read injection
        pn = mk(32'h1234);
        load_done = 1'b1; new_read_valid = 1'b1; new_read_payload = pn;
        #1;
        chk("inj_newread", 1024'(new_read), 1024'(1));
        tick();
        load_done = 1'b0; new_read_valid = 1'b0;
        chk("inj_status",  1024'(out_status), 1024'(0));
        chk("inj_payload", 1024'(out_payload), 1024'(pn));
        chk("inj_query",   1024'(out_query), 1024'(0));
        chk("inj_mem",     1024'(out_mem), 1024'(0));

        // Single F_run entry paired with a response
        pa = mk(32'hAAAA);
        in_status = 6'd1; in_payload = pa;       // cycle T
        tick(); in_status = BUB;                  // T+1
        tick();                                   // T+2
        tick(); query_data = 8'h02;               // T+3
        tick(); query_data = 8'h00;               // T+4
        chk("p_entcnt", 1024'(ent_count), 1024'(1));
        tick();                                   // T+5
        tick(); mem_valid = 1'b1; mem_data = ma;  // T+6
        tick(); mem_valid = 1'b0;                 // T+7
        chk("p_memcnt",   1024'(mem_count), 1024'(1));
        chk("p_prestat",  1024'(out_status), 1024'(BUB));
        tick();                                   // T+8
        chk("p_status",   1024'(out_status), 1024'(1));
        chk("p_payload",  1024'(out_payload), 1024'(pa));
        chk("p_query",    1024'(out_query), 1024'(8'h02));
        chk("p_mem",      1024'(out_mem), 1024'(ma));
        chk("p_entcnt0",  1024'(ent_count), 1024'(0));
        chk("p_memcnt0",  1024'(mem_count), 1024'(0));

        // A (F_run) then B (F_break), one response
        pa = mk(32'h0A0A); pb = mk(32'h0B0B);
        in_status = 6'd1; in_payload = pa;        // T
        tick(); in_status = 6'd2; in_payload = pb; // T+1
        tick(); in_status = BUB;                   // T+2
        tick(); query_data = 8'h11;                // T+3
        tick(); query_data = 8'h22;                // T+4
        tick(); query_data = 8'h00;                // T+5
        mem_valid = 1'b1; mem_data = mb;
        chk("ab_entcnt", 1024'(ent_count), 1024'(2));
        tick(); mem_valid = 1'b0;                  // T+6
        chk("ab_memcnt", 1024'(mem_count), 1024'(1));
        tick();                                    // T+7
        chk("a_status",  1024'(out_status), 1024'(1));
        chk("a_payload", 1024'(out_payload), 1024'(pa));
        chk("a_query",   1024'(out_query), 1024'(8'h11));
        chk("a_mem",     1024'(out_mem), 1024'(mb));
        tick();                                    // T+8
        chk("b_status",  1024'(out_status), 1024'(2));
        chk("b_payload", 1024'(out_payload), 1024'(pb));
        chk("b_query",   1024'(out_query), 1024'(8'h22));
        chk("b_mem",     1024'(out_mem), 1024'(0));
        chk("b_entcnt",  1024'(ent_count), 1024'(0));
        chk("b_memcnt",  1024'(mem_count), 1024'(0));

        // Fill the ring to DEPTH, then one extra entry
        do_reset();
        query_data = 8'h5A;
        for (int i = 0; i < DEP; i++) begin
            in_status = 6'd1; in_payload = mk(i);
            tick();
        end
        in_status = BUB;
        for (int i = 0; i < QL + 1; i++) tick();
        chk("f_full",   1024'(ent_full), 1024'(1));
        chk("f_entcnt", 1024'(ent_count), 1024'(DEP));
        chk("f_ovf0",   1024'(ovf_err), 1024'(0));
        in_status = 6'd1; in_payload = mk(99);
        tick(); in_status = BUB;
        for (int i = 0; i < QL + 1; i++) tick();
        chk("f_ovf1",    1024'(ovf_err), 1024'(1));
        chk("f_entcnt2", 1024'(ent_count), 1024'(DEP));
        chk("f_full2",   1024'(ent_full), 1024'(1));

        // Stall for 5 cycles with a pending pair
        stall = 1'b1; load_done = 1'b1; new_read_valid = 1'b1;
        mem_valid = 1'b1; mem_data = mc;
        #1;
        chk("s_newread", 1024'(new_read), 1024'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            mem_valid = 1'b0;
            chk("s_status",  1024'(out_status), 1024'(BUB));
            chk("s_payload", 1024'(out_payload), 1024'(ones_p));
            if (k == 4) stall = 1'b0;
        end
        chk("s_memcnt", 1024'(mem_count), 1024'(1));
        tick();
        load_done = 1'b0; new_read_valid = 1'b0;
        chk("s_status_go",  1024'(out_status), 1024'(1));
        chk("s_payload_go", 1024'(out_payload), 1024'(mk(0)));
        chk("s_query_go",   1024'(out_query), 1024'(8'h5A));
        chk("s_mem_go",     1024'(out_mem), 1024'(mc));
        chk("s_memcnt0",    1024'(mem_count), 1024'(0));
        chk("s_entcnt",     1024'(ent_count), 1024'(DEP - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
